systolic_mac_array: RTL and testbench

//  N x N output-stationary systolic MAC array fed by the input control stage.
//  Row i of X enters the left edge of row i and column j of Y enters the top of column j.

---
 rtl/systolic_mac_array.sv | 103 ++++++++++
 tb/tb_systolic_mac_array.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_array.sv
// Output-stationary N x N systolic MAC array.
// Skewed X rows enter from the left, skewed Y columns from the top.
module systolic_mac_array #(
  parameter int D_W    = 8,
  parameter int N      = 2,
  parameter int WORD   = 8,
  parameter int IN_DLY = 2,
  parameter int ACC_W  = 2*D_W+$clog2(WORD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic [N*D_W-1:0]     x_flat,
  input  logic [N*D_W-1:0]     y_flat,
  output logic                 busy,
  output logic                 result_valid,
  output logic [N*N*ACC_W-1:0] result_flat
);

  localparam int RUN_CYC = IN_DLY + WORD + 2*N - 3;
  localparam int CNT_W   = $clog2(RUN_CYC + 1);
  localparam int PW      = 2*D_W;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(RUN_CYC - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  logic [D_W-1:0]   a_reg [N][N];
  logic [D_W-1:0]   b_reg [N][N];
  logic [D_W-1:0]   a_in  [N][N];
  logic [D_W-1:0]   b_in  [N][N];
  logic [PW-1:0]    prod  [N][N];
  logic [ACC_W-1:0] acc   [N][N];

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        if (gj == 0) begin : g_a_edge
          assign a_in[gi][gj] = x_flat[(gi+1)*D_W-1 -: D_W];
        end else begin : g_a_pass
          assign a_in[gi][gj] = a_reg[gi][gj-1];
        end
        if (gi == 0) begin : g_b_edge
          assign b_in[gi][gj] = y_flat[(gj+1)*D_W-1 -: D_W];
        end else begin : g_b_pass
          assign b_in[gi][gj] = b_reg[gi-1][gj];
        end
        assign prod[gi][gj] = PW'(a_in[gi][gj]) * PW'(b_in[gi][gj]);
        assign result_flat[(gi*N+gj+1)*ACC_W-1 -: ACC_W] = acc[gi][gj];
      end
    end
  endgenerate

  // Control FSM plus PE registers: clear on reset/init, MAC while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
          acc[i][j]   <= '0;
        end
      end
    end else if (init) begin
      state        <= RUN;
      cnt          <= '0;
      busy         <= 1'b1;
      result_valid <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
          acc[i][j]   <= '0;
        end
      end
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_reg[i][j] <= a_in[i][j];
          b_reg[i][j] <= b_in[i][j];
          acc[i][j]   <= acc[i][j] + ACC_W'(prod[i][j]);
        end
      end
      if (cnt == LAST) begin
        state        <= DONE;
        busy         <= 1'b0;
        result_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Bench for systolic_mac_array: random and directed matrices
// checked against a plain matrix-multiply model.
module tb_systolic_mac_array;

  localparam int D_W     = 8;
  localparam int N       = 2;
  localparam int WORD    = 2;
  localparam int IN_DLY  = 2;
  localparam int ACC_W   = 17;
  localparam int ACC_S   = 16;
  localparam int RUN_CYC = IN_DLY + WORD + 2*N - 3;

  logic clk = 1'b0;
  logic rst;
  logic init;
  logic [N*D_W-1:0] x_flat;
  logic [N*D_W-1:0] y_flat;
  logic busy, rv;
  logic [N*N*ACC_W-1:0] rf;
  logic busy_s, rv_s;
  logic [N*N*ACC_S-1:0] rf_s;

  int total = 0;
  int bad = 0;

  int xm [N][WORD];
  int ym [WORD][N];

  systolic_mac_array #(
    .D_W(D_W), .N(N), .WORD(WORD), .IN_DLY(IN_DLY), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .init(init),
    .x_flat(x_flat), .y_flat(y_flat),
    .busy(busy), .result_valid(rv), .result_flat(rf)
  );

  systolic_mac_array #(
    .D_W(D_W), .N(N), .WORD(WORD), .IN_DLY(IN_DLY), .ACC_W(ACC_S)
  ) dut_s (
    .clk(clk), .rst(rst), .init(init),
    .x_flat(x_flat), .y_flat(y_flat),
    .busy(busy_s), .result_valid(rv_s), .result_flat(rf_s)
  );

  always #5 clk = ~clk;

  function automatic longint get_c(int i, int j);
    return longint'(rf[(i*N+j)*ACC_W +: ACC_W]);
  endfunction

  function automatic longint get_cs(int i, int j);
    return longint'(rf_s[(i*N+j)*ACC_S +: ACC_S]);
  endfunction

  function automatic longint model_c(int i, int j, int w);
    longint s = 0;
    for (int k = 0; k < WORD; k++)
      s += longint'(xm[i][k]) * longint'(ym[k][j]);
    return s & ((longint'(1) << w) - 1);
  endfunction

  // Present the words that must be sampled on edge e after init.
  task automatic set_lanes(int e);
    int k;
    for (int i = 0; i < N; i++) begin
      k = e - IN_DLY - i;
      x_flat[i*D_W +: D_W] = (k >= 0 && k < WORD) ? D_W'(xm[i][k]) : '0;
      y_flat[i*D_W +: D_W] = (k >= 0 && k < WORD) ? D_W'(ym[k][i]) : '0;
    end
  endtask

  task automatic rand_mats();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < WORD; k++) begin
        xm[i][k] = int'($urandom_range(0, 255));
        ym[k][i] = int'($urandom_range(0, 255));
      end
  endtask

  // Called at a negedge; returns at a negedge once the run has ended.
  task automatic run_full(output int bcyc, output int rv_edge,
                          output logic rv0);
    init = 1'b1;
    x_flat = '0;
    y_flat = '0;
    bcyc = 0;
    rv_edge = -1;
    rv0 = 1'b1;
    for (int e = 1; e <= RUN_CYC + 2; e++) begin
      @(negedge clk);
      init = 1'b0;
      set_lanes(e);
      if (e == 1) rv0 = rv;
      if (busy) bcyc++;
      if (rv && rv_edge < 0) rv_edge = e - 1;
    end
  endtask

  // Called at a negedge; leaves after edges 0..n-1 of a run.
  task automatic partial_run(int n);
    init = 1'b1;
    x_flat = '0;
    y_flat = '0;
    for (int e = 1; e <= n; e++) begin
      @(negedge clk);
      init = 1'b0;
      set_lanes(e);
    end
  endtask

  task automatic set_t1();
    xm[0][0] = 1; xm[0][1] = 2; xm[1][0] = 3; xm[1][1] = 4;
    ym[0][0] = 5; ym[0][1] = 6; ym[1][0] = 7; ym[1][1] = 8;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    init = 1'b0;
    x_flat = '0;
    y_flat = '0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b want=0", busy);
    end
    total++;
    if (rv !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b want=0", rv);
    end
    total++;
    if (rf !== '0) begin
      bad++; $display("FAIL reset_result got=%h want=0", rf);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int bc, re;
    logic r0;
    longint want [N][N];
    set_t1();
    want[0][0] = 19; want[0][1] = 22; want[1][0] = 43; want[1][1] = 50;
    run_full(bc, re, r0);
    total++;
    if (re != RUN_CYC) begin
      bad++; $display("FAIL basic_valid_edge got=%0d want=%0d", re, RUN_CYC);
    end
    total++;
    if (bc != RUN_CYC) begin
      bad++; $display("FAIL basic_busy_cycles got=%0d want=%0d", bc, RUN_CYC);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        total++;
        if (get_c(i, j) !== want[i][j]) begin
          bad++;
          $display("FAIL basic_c%0d%0d got=%0d want=%0d",
                   i, j, get_c(i, j), want[i][j]);
        end
      end
  endtask

  task automatic test_max();
    int bc, re;
    logic r0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < WORD; k++) begin
        xm[i][k] = 255;
        ym[k][i] = 255;
      end
    run_full(bc, re, r0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        total++;
        if (get_c(i, j) !== 130050) begin
          bad++;
          $display("FAIL max17_c%0d%0d got=%0d want=130050", i, j, get_c(i, j));
        end
        total++;
        if (get_cs(i, j) !== 64514) begin
          bad++;
          $display("FAIL max16_c%0d%0d got=%0d want=64514", i, j, get_cs(i, j));
        end
      end
  endtask

  task automatic test_hold_restart();
    int bc, re;
    logic r0;
    longint want [N][N];
    set_t1();
    run_full(bc, re, r0);
    for (int c = 0; c < 10; c++) begin
      x_flat = N*D_W'($urandom);
      y_flat = N*D_W'($urandom);
      @(negedge clk);
      total++;
      if (rv !== 1'b1) begin
        bad++; $display("FAIL hold_valid cyc=%0d got=%b want=1", c, rv);
      end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          total++;
          if (get_c(i, j) !== model_c(i, j, ACC_W)) begin
            bad++;
            $display("FAIL hold_c%0d%0d cyc=%0d got=%0d want=%0d",
                     i, j, c, get_c(i, j), model_c(i, j, ACC_W));
          end
        end
    end
    xm[0][0] = 1; xm[0][1] = 0; xm[1][0] = 0; xm[1][1] = 1;
    ym[0][0] = 9; ym[0][1] = 1; ym[1][0] = 2; ym[1][1] = 3;
    want[0][0] = 9; want[0][1] = 1; want[1][0] = 2; want[1][1] = 3;
    run_full(bc, re, r0);
    total++;
    if (r0 !== 1'b0) begin
      bad++; $display("FAIL restart_valid_drop got=%b want=0", r0);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        total++;
        if (get_c(i, j) !== want[i][j]) begin
          bad++;
          $display("FAIL restart_c%0d%0d got=%0d want=%0d",
                   i, j, get_c(i, j), want[i][j]);
        end
      end
  endtask

  task automatic test_restart_mid();
    int bc, re;
    logic r0;
    rand_mats();
    for (int i = 0; i < N; i++) xm[i][0] = 200 + i;
    partial_run(3);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL midrun_busy got=%b want=1", busy);
    end
    set_t1();
    run_full(bc, re, r0);
    total++;
    if (re != RUN_CYC) begin
      bad++; $display("FAIL midrun_valid_edge got=%0d want=%0d", re, RUN_CYC);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        total++;
        if (get_c(i, j) !== model_c(i, j, ACC_W)) begin
          bad++;
          $display("FAIL midrun_c%0d%0d got=%0d want=%0d",
                   i, j, get_c(i, j), model_c(i, j, ACC_W));
        end
      end
  endtask

  task automatic test_reset_mid();
    rand_mats();
    partial_run(4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (busy !== 1'b0 || rv !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_flags cyc=%0d got=%b%b want=00", c, busy, rv);
      end
      total++;
      if (rf !== '0) begin
        bad++; $display("FAIL rstmid_result cyc=%0d got=%h want=0", c, rf);
      end
      x_flat = N*D_W'($urandom) | 16'h0101;
      y_flat = N*D_W'($urandom) | 16'h0101;
      @(negedge clk);
    end
  endtask

  task automatic test_zero();
    int bc, re;
    logic r0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < WORD; k++) begin
        xm[i][k] = 0;
        ym[k][i] = 0;
      end
    run_full(bc, re, r0);
    total++;
    if (rv !== 1'b1) begin
      bad++; $display("FAIL zero_valid got=%b want=1", rv);
    end
    total++;
    if (rf !== '0) begin
      bad++; $display("FAIL zero_result got=%h want=0", rf);
    end
  endtask

  task automatic test_back_to_back();
    int bc, re;
    logic r0;
    for (int t = 0; t < 8; t++) begin
      rand_mats();
      run_full(bc, re, r0);
      total++;
      if (re != RUN_CYC || bc != RUN_CYC) begin
        bad++;
        $display("FAIL b2b_timing run=%0d got=%0d/%0d want=%0d",
                 t, re, bc, RUN_CYC);
      end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          total++;
          if (get_c(i, j) !== model_c(i, j, ACC_W) ||
              get_cs(i, j) !== model_c(i, j, ACC_S)) begin
            bad++;
            $display("FAIL b2b_c%0d%0d run=%0d got=%0d/%0d want=%0d/%0d",
                     i, j, t, get_c(i, j), get_cs(i, j),
                     model_c(i, j, ACC_W), model_c(i, j, ACC_S));
          end
        end
    end
  endtask

  initial begin
    rst = 1'b1;
    init = 1'b0;
    x_flat = '0;
    y_flat = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_max();
    test_hold_restart();
    test_restart_mid();
    test_reset_mid();
    test_zero();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
